// File: rtl/kernel_switch_pkg.sv
// Shared types and constants for the double-buffered kernel switch.
package kernel_switch_pkg;

  typedef enum logic {K3X3 = 1'b0, K1X1 = 1'b1} kmode_e;

  localparam logic [1:0] PH_ROW0 = 2'd0;
  localparam logic [1:0] PH_ROW1 = 2'd1;
  localparam logic [1:0] PH_ROW2 = 2'd2;
  localparam logic [1:0] PH_BIAS = 2'd3;

  localparam int WORDS_3X3 = 10;
  localparam int WORDS_1X1 = 2;
  // Bias lives in the last per-core slot in both modes.
  localparam int BIAS_SLOT = 9;

  function automatic int load_len(kmode_e mode, int cores);
    return ((mode == K1X1) ? WORDS_1X1 : WORDS_3X3) * cores;
  endfunction

endpackage

// File: rtl/kernel_switch_dbuf_bank.sv
// Per-core weight register file: indexed write, full-parallel read, one-cycle bulk copy.
module kernel_bank
  import kernel_switch_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CORES      = 4
) (
  input  logic                                    clk,
  input  logic                                    we_i,
  input  logic [$clog2(CORES*WORDS_3X3)-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0]                   wdata_i,
  input  logic                                    copy_i,
  input  logic [CORES*WORDS_3X3*DATA_WIDTH-1:0]   copy_data_i,
  output logic [CORES*WORDS_3X3*DATA_WIDTH-1:0]   rd_o
);

  localparam int DEPTH = CORES * WORDS_3X3;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (copy_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= copy_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_rd
    assign rd_o[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
  end

endmodule

// File: rtl/kernel_switch_dbuf.sv
// Double-buffered kernel switch: streams weights into a shadow bank, swaps on release,
// and presents per-core L/M/R kernel triplets row by row.
module kernel_switch_dbuf
  import kernel_switch_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CORES      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_k1,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [1:0]                  m_phase,
  output logic                        m_last,
  output logic [CORES*DATA_WIDTH-1:0] L_kernel,
  output logic [CORES*DATA_WIDTH-1:0] M_kernel,
  output logic [CORES*DATA_WIDTH-1:0] R_kernel,
  input  logic                        release_i,
  output logic                        err_len
);

  localparam int DEPTH = CORES * WORDS_3X3;
  localparam int AW    = $clog2(DEPTH);
  localparam int CIW   = (CORES > 1) ? $clog2(CORES) : 1;

  logic [AW-1:0]  cnt_q, cnt_d;
  logic [CIW-1:0] core_q, core_d;
  logic [3:0]     off_q, off_d;
  kmode_e         ld_mode_q, ld_mode_d;
  logic           shadow_full_q, shadow_full_d;
  kmode_e         sh_mode_q, sh_mode_d;
  logic           active_valid_q, active_valid_d;
  kmode_e         act_mode_q, act_mode_d;
  logic [1:0]     phase_q, phase_d;
  logic           err_q, err_d;

  logic           accept, load_end, swap;
  kmode_e         cur_mode;
  logic [3:0]     core_last_off, slot;
  logic [AW-1:0]  waddr;
  logic [1:0]     last_ph;
  logic [DEPTH*DATA_WIDTH-1:0] sh_rd, act_rd;

  assign accept        = s_valid && !shadow_full_q;
  // Mode is taken from cfg_k1 only on the first word of a load.
  assign cur_mode      = (cnt_q == '0) ? kmode_e'(cfg_k1) : ld_mode_q;
  assign core_last_off = (cur_mode == K1X1) ? 4'd1 : 4'd9;
  assign load_end      = (cnt_q == AW'(load_len(cur_mode, CORES) - 1));
  assign slot          = (cur_mode == K1X1 && off_q == 4'd1) ? 4'(BIAS_SLOT) : off_q;
  assign waddr         = AW'(int'(core_q) * WORDS_3X3 + int'(slot));
  assign swap          = shadow_full_q && (!active_valid_q || release_i);
  assign last_ph       = (act_mode_q == K1X1) ? PH_ROW1 : PH_BIAS;

  always_comb begin
    cnt_d          = cnt_q;
    core_d         = core_q;
    off_d          = off_q;
    ld_mode_d      = ld_mode_q;
    shadow_full_d  = shadow_full_q;
    sh_mode_d      = sh_mode_q;
    active_valid_d = active_valid_q;
    act_mode_d     = act_mode_q;
    phase_d        = phase_q;
    err_d          = err_q;

    if (accept) begin
      if (cnt_q == '0) ld_mode_d = kmode_e'(cfg_k1);
      if (s_last != load_end) err_d = 1'b1;
      if (load_end) begin
        cnt_d         = '0;
        core_d        = '0;
        off_d         = '0;
        shadow_full_d = 1'b1;
        sh_mode_d     = cur_mode;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (off_q == core_last_off) begin
          off_d  = '0;
          core_d = core_q + 1'b1;
        end else begin
          off_d = off_q + 4'd1;
        end
      end
    end

    // Release takes priority over the output handshake.
    if (swap) begin
      active_valid_d = 1'b1;
      act_mode_d     = sh_mode_q;
      phase_d        = PH_ROW0;
      shadow_full_d  = 1'b0;
    end else if (release_i) begin
      active_valid_d = 1'b0;
      phase_d        = PH_ROW0;
    end else if (active_valid_q && m_ready) begin
      phase_d = (phase_q == last_ph) ? PH_ROW0 : phase_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      core_q         <= '0;
      off_q          <= '0;
      ld_mode_q      <= K3X3;
      shadow_full_q  <= 1'b0;
      sh_mode_q      <= K3X3;
      active_valid_q <= 1'b0;
      act_mode_q     <= K3X3;
      phase_q        <= PH_ROW0;
      err_q          <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      core_q         <= core_d;
      off_q          <= off_d;
      ld_mode_q      <= ld_mode_d;
      shadow_full_q  <= shadow_full_d;
      sh_mode_q      <= sh_mode_d;
      active_valid_q <= active_valid_d;
      act_mode_q     <= act_mode_d;
      phase_q        <= phase_d;
      err_q          <= err_d;
    end
  end

  kernel_bank #(.DATA_WIDTH(DATA_WIDTH), .CORES(CORES)) u_shadow (
    .clk         (clk),
    .we_i        (accept),
    .waddr_i     (waddr),
    .wdata_i     (s_data),
    .copy_i      (1'b0),
    .copy_data_i ('0),
    .rd_o        (sh_rd)
  );

  kernel_bank #(.DATA_WIDTH(DATA_WIDTH), .CORES(CORES)) u_active (
    .clk         (clk),
    .we_i        (1'b0),
    .waddr_i     ('0),
    .wdata_i     ('0),
    .copy_i      (swap),
    .copy_data_i (sh_rd),
    .rd_o        (act_rd)
  );

  // Row select: L slot for the current phase, M/R follow it except in bias/1x1 phases.
  int   l_slot;
  logic mr_en;

  always_comb begin
    l_slot   = 0;
    mr_en    = 1'b0;
    L_kernel = '0;
    M_kernel = '0;
    R_kernel = '0;
    if (act_mode_q == K1X1) begin
      l_slot = (phase_q == PH_ROW0) ? 0 : BIAS_SLOT;
    end else if (phase_q == PH_BIAS) begin
      l_slot = BIAS_SLOT;
    end else begin
      l_slot = 3 * int'(phase_q);
      mr_en  = 1'b1;
    end
    if (active_valid_q) begin
      for (int c = 0; c < CORES; c++) begin
        L_kernel[c*DATA_WIDTH +: DATA_WIDTH] = act_rd[(c*WORDS_3X3 + l_slot)*DATA_WIDTH +: DATA_WIDTH];
        if (mr_en) begin
          M_kernel[c*DATA_WIDTH +: DATA_WIDTH] = act_rd[(c*WORDS_3X3 + l_slot + 1)*DATA_WIDTH +: DATA_WIDTH];
          R_kernel[c*DATA_WIDTH +: DATA_WIDTH] = act_rd[(c*WORDS_3X3 + l_slot + 2)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign s_ready = !shadow_full_q;
  assign m_valid = active_valid_q;
  assign m_phase = phase_q;
  assign m_last  = active_valid_q && (phase_q == last_ph);
  assign err_len = err_q;

endmodule
